// File: rtl/sample_packer_if.sv
// sample_packer_if: record input strobe and byte-serial sample handshake bundle
interface sample_packer_if #(parameter int REC_BYTES = 6);
  logic [8*REC_BYTES-1:0] rec_data;
  logic                   rec_strobe;
  logic [7:0]             sample;
  logic                   sample_rdy;
  logic                   sample_ack;
  modport master (output rec_data, rec_strobe, sample_ack, input sample, sample_rdy);
  modport slave  (input rec_data, rec_strobe, sample_ack, output sample, sample_rdy);
endinterface

// File: rtl/sample_packer.sv
// sample_packer: buffers timetag records and streams them MSB-byte-first to the FX2 sample port
module sample_packer #(
  parameter int REC_BYTES = 6,
  parameter int DEPTH     = 4,
  parameter int AW        = 2
) (
  input  logic             fx2_clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clr_lost,
  sample_packer_if.slave   bus,
  output logic [15:0]      lost_count,
  output logic             overflow
);
  localparam int IW = $clog2(REC_BYTES);
  logic [REC_BYTES-1:0][7:0] mem_q [DEPTH];
  logic [REC_BYTES-1:0][7:0] mem_d [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0] idx_q, idx_d, sel;
  logic [15:0]   lost_q, lost_d;
  logic          ovf_q, ovf_d;
  logic          acc, pop, full, push, drop;
  assign bus.sample_rdy = count_q != '0;
  assign sel            = IW'(REC_BYTES - 1) - idx_q;
  assign bus.sample     = bus.sample_rdy ? mem_q[rd_q][sel] : 8'h00;
  assign lost_count     = lost_q;
  assign overflow       = ovf_q;
  // handshake decode, FIFO bookkeeping and drop accounting
  always_comb begin
    acc     = bus.sample_ack & bus.sample_rdy;
    pop     = acc & (idx_q == IW'(REC_BYTES - 1));
    full    = count_q == (AW+1)'(DEPTH);
    push    = bus.rec_strobe & enable & (~full | pop);
    drop    = bus.rec_strobe & enable & full & ~pop;
    idx_d   = pop ? '0 : idx_q + IW'(acc);
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    lost_d  = clr_lost ? 16'(drop) : lost_q + 16'(drop && lost_q != 16'hFFFF);
    ovf_d   = drop | (ovf_q & ~clr_lost);
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = bus.rec_data;
  end
  // state registers, asynchronously cleared
  always_ff @(posedge fx2_clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      lost_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
      lost_q  <= lost_d;
      ovf_q   <= ovf_d;
    end
endmodule
